// File: rtl/vga_rect_fill.sv
// vga_rect_fill: rectangle / full-screen fill pixel-stream generator for the vga block.
// Scans a latched rectangle row-major, one pixel per unpaused cycle. Pixels that
// fall off the 160x120 screen are suppressed (plot=0) but still take their cycle.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   start, clear        one-cycle command requests (clear wins), sampled only in IDLE
//   rect_x/y/w/h/colour rectangle origin, size (0 allowed) and fill colour
//   pause               freezes the scan while high (DRAW only)
//   x, y, colour, plot  registered pixel write bus to vga
//   busy, done          command in progress / one-cycle completion pulse
module vga_rect_fill #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       clear,
  input  logic [7:0] rect_x,
  input  logic [6:0] rect_y,
  input  logic [7:0] rect_w,
  input  logic [6:0] rect_h,
  input  logic [2:0] rect_colour,
  input  logic       pause,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x0_q, x0_d, w_q, w_d, col_q, col_d;
  logic [YW-1:0] y0_q, y0_d, h_q, h_d, row_q, row_d;
  logic [CW-1:0] fill_q, fill_d;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_d;
  logic [CW-1:0] colour_d;
  logic          plot_d, busy_d, done_d;

  // Unwrapped screen coordinates of the current pixel, for clipping.
  logic [XW:0]   x_sum;
  logic [YW:0]   y_sum;
  logic          last_col, last_row;

  assign x_sum    = (XW+1)'(x0_q) + (XW+1)'(col_q);
  assign y_sum    = (YW+1)'(y0_q) + (YW+1)'(row_q);
  assign last_col = (col_q == XW'(w_q - XW'(1)));
  assign last_row = (row_q == YW'(h_q - YW'(1)));

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    fill_d   = fill_q;
    col_d    = col_q;
    row_d    = row_q;
    x_d      = x;
    y_d      = y;
    colour_d = colour;
    plot_d   = 1'b0;
    busy_d   = busy;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (clear || start) begin
          if (clear) begin
            x0_d   = '0;
            y0_d   = '0;
            w_d    = XW'(SCREEN_W);
            h_d    = YW'(SCREEN_H);
            fill_d = '0;
          end else begin
            x0_d   = rect_x;
            y0_d   = rect_y;
            w_d    = rect_w;
            h_d    = rect_h;
            fill_d = rect_colour;
          end
          col_d  = '0;
          row_d  = '0;
          busy_d = 1'b1;
          // Empty rectangles skip straight to the completion pulse.
          state_d = ((w_d == '0) || (h_d == '0)) ? DONE : DRAW;
        end
      end

      DRAW: begin
        if (!pause) begin
          x_d      = x_sum[XW-1:0];
          y_d      = y_sum[YW-1:0];
          colour_d = fill_q;
          plot_d   = (x_sum < (XW+1)'(SCREEN_W)) && (y_sum < (YW+1)'(SCREEN_H));
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = DONE;
            end else begin
              row_d = YW'(row_q + YW'(1));
            end
          end else begin
            col_d = XW'(col_q + XW'(1));
          end
        end
      end

      DONE: begin
        // First DONE cycle raises done; the next returns to IDLE so the
        // cycle with done=1 never accepts a command.
        if (!done) begin
          done_d = 1'b1;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      fill_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      fill_q  <= fill_d;
      col_q   <= col_d;
      row_q   <= row_d;
      x       <= x_d;
      y       <= y_d;
      colour  <= colour_d;
      plot    <= plot_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
// tb_vga_rect_fill: directed self-checking bench for vga_rect_fill.
// Every cycle's expected {plot, x, y, colour, busy, done} is hand-derived below.
module tb_vga_rect_fill;

  logic       clock;
  logic       reset;
  logic       start;
  logic       clear;
  logic [7:0] rect_x;
  logic [6:0] rect_y;
  logic [7:0] rect_w;
  logic [6:0] rect_h;
  logic [2:0] rect_colour;
  logic       pause;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  vga_rect_fill dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .clear       (clear),
    .rect_x      (rect_x),
    .rect_y      (rect_y),
    .rect_w      (rect_w),
    .rect_h      (rect_h),
    .rect_colour (rect_colour),
    .pause       (pause),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packed view: {plot, x, y, colour, busy, done}.
  function automatic logic [20:0] pk(input logic p, input logic [7:0] xx, input logic [6:0] yy,
                                     input logic [2:0] c, input logic b, input logic d);
    return {p, xx, yy, c, b, d};
  endfunction

  function automatic logic [20:0] obs();
    return {plot, x, y, colour, busy, done};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [20:0] o, input logic [20:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed plot/x/y/col/busy/done=%0d/%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d/%0d",
             tag, o[20], o[19:12], o[11:5], o[4:2], o[1], o[0],
             e[20], e[19:12], e[11:5], e[4:2], e[1], e[0]);
    end
  endtask

  task automatic set_rect(input logic [7:0] rx, input logic [6:0] ry, input logic [7:0] rw,
                          input logic [6:0] rh, input logic [2:0] rc);
    rect_x      = rx;
    rect_y      = ry;
    rect_w      = rw;
    rect_h      = rh;
    rect_colour = rc;
  endtask

  initial begin
    int ex;
    int ey;

    // Reset held two edges with random command inputs.
    reset = 1'b0;
    start = 1'($urandom);
    clear = 1'($urandom);
    pause = 1'($urandom);
    set_rect(8'($urandom), 7'($urandom), 8'($urandom), 7'($urandom), 3'($urandom));
    tick();
    start = 1'($urandom);
    clear = 1'($urandom);
    tick();
    check("reset_state", obs(), pk(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0));
    reset = 1'b1;
    start = 1'b0;
    clear = 1'b0;
    pause = 1'b0;
    tick();
    check("idle_after_reset", obs(), pk(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0));

    // Rectangle 3x2 at (10,5), colour 101.
    set_rect(8'd10, 7'd5, 8'd3, 7'd2, 3'b101);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rect_accept", obs(), pk(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0));
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rect_px", obs(), pk(1'b1, 8'(10 + i % 3), 7'(5 + i / 3), 3'b101, 1'b1, 1'b0));
    end
    tick();
    check("rect_done", obs(), pk(1'b0, 8'd12, 7'd6, 3'b101, 1'b1, 1'b1));
    // A start presented during the done cycle must be dropped.
    set_rect(8'd1, 7'd1, 8'd1, 7'd1, 3'b111);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rect_idle", obs(), pk(1'b0, 8'd12, 7'd6, 3'b101, 1'b0, 1'b0));
    tick();
    check("done_cycle_no_accept", obs(), pk(1'b0, 8'd12, 7'd6, 3'b101, 1'b0, 1'b0));

    // Clipping: 4x2 at (158,119), colour 010; only two pixels on screen.
    set_rect(8'd158, 7'd119, 8'd4, 7'd2, 3'b010);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("clip_accept", obs(), pk(1'b0, 8'd12, 7'd6, 3'b101, 1'b1, 1'b0));
    for (int i = 0; i < 8; i++) begin
      ex = 158 + i % 4;
      ey = 119 + i / 4;
      tick();
      check("clip_px", obs(), pk(1'((ex < 160) && (ey < 120)), 8'(ex), 7'(ey), 3'b010, 1'b1, 1'b0));
    end
    tick();
    check("clip_done", obs(), pk(1'b0, 8'd161, 7'd120, 3'b010, 1'b1, 1'b1));
    tick();
    check("clip_idle", obs(), pk(1'b0, 8'd161, 7'd120, 3'b010, 1'b0, 1'b0));

    // start and clear together: clear wins and fills the full screen with 000.
    set_rect(8'd3, 7'd3, 8'd1, 7'd1, 3'b111);
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    check("clear_accept", obs(), pk(1'b0, 8'd161, 7'd120, 3'b010, 1'b1, 1'b0));
    ex = 0;
    ey = 0;
    for (int i = 0; i < 19200; i++) begin
      tick();
      check("clear_px", obs(), pk(1'b1, 8'(ex), 7'(ey), 3'b000, 1'b1, 1'b0));
      start = (i == 100);
      ex++;
      if (ex == 160) begin
        ex = 0;
        ey++;
      end
    end
    start = 1'b0;
    tick();
    check("clear_done", obs(), pk(1'b0, 8'd159, 7'd119, 3'b000, 1'b1, 1'b1));
    tick();
    check("clear_idle", obs(), pk(1'b0, 8'd159, 7'd119, 3'b000, 1'b0, 1'b0));

    // Zero width: done the cycle after accept, no plot.
    set_rect(8'd7, 7'd7, 8'd0, 7'd4, 3'b110);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_accept", obs(), pk(1'b0, 8'd159, 7'd119, 3'b000, 1'b1, 1'b0));
    tick();
    check("zero_done", obs(), pk(1'b0, 8'd159, 7'd119, 3'b000, 1'b1, 1'b1));
    tick();
    check("zero_idle", obs(), pk(1'b0, 8'd159, 7'd119, 3'b000, 1'b0, 1'b0));

    // Pause mid-rect (2x2 at (20,30), colour 011), then reset during DRAW.
    set_rect(8'd20, 7'd30, 8'd2, 7'd2, 3'b011);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pause_px0", obs(), pk(1'b1, 8'd20, 7'd30, 3'b011, 1'b1, 1'b0));
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pause_hold", obs(), pk(1'b0, 8'd20, 7'd30, 3'b011, 1'b1, 1'b0));
    end
    pause = 1'b0;
    tick();
    check("pause_px1", obs(), pk(1'b1, 8'd21, 7'd30, 3'b011, 1'b1, 1'b0));
    tick();
    check("pause_px2", obs(), pk(1'b1, 8'd20, 7'd31, 3'b011, 1'b1, 1'b0));
    reset = 1'b0;
    tick();
    check("abort_reset", obs(), pk(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0));
    reset = 1'b1;
    tick();
    check("abort_no_done", obs(), pk(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0));
    tick();
    check("abort_idle", obs(), pk(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
